// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus for the sequential divider.
interface seq_divider_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one trial subtraction per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operation (one extra fix-up edge).
module seq_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   seq_divider_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam logic [1:0] S_FIX  = 2'd3;
`endif

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
`endif

   logic [WIDTH:0]   t;
   logic [WIDTH-1:0] r_nx;
   logic [WIDTH-1:0] q_nx;
   logic [WIDTH-1:0] dvd_in;
   logic [WIDTH-1:0] dvs_in;

   // Next-state, datapath iteration and registered outputs
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dvd_in = bus.dividend[WIDTH-1] ? WIDTH'(WIDTH'(0) - bus.dividend) : bus.dividend;
      dvs_in = bus.divisor[WIDTH-1]  ? WIDTH'(WIDTH'(0) - bus.divisor)  : bus.divisor;
`else
      dvd_in = bus.dividend;
      dvs_in = bus.divisor;
`endif

      // Trial subtraction on the shifted partial remainder; MSB set means it went negative
      t    = {r_q, q_q[WIDTH-1]} - {1'b0, dvs_q};
      r_nx = t[WIDTH] ? {r_q[WIDTH-2:0], q_q[WIDTH-1]} : t[WIDTH-1:0];
      q_nx = {q_q[WIDTH-2:0], ~t[WIDTH]};

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.start) begin
               if (bus.divisor == WIDTH'(0)) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  quo_d   = '1;
                  rem_d   = bus.dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = S_RUN;
                  dbz_d   = 1'b0;
                  r_d     = '0;
                  q_d     = dvd_in;
                  dvs_d   = dvs_in;
                  cnt_d   = CW'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
                  neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                  neg_rem_d = bus.dividend[WIDTH-1];
`endif
               end
            end
         end
         S_RUN: begin
            r_d   = r_nx;
            q_d   = q_nx;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
               state_d = S_FIX;
`else
               state_d = S_DONE;
               done_d  = 1'b1;
               quo_d   = q_nx;
               rem_d   = r_nx;
`endif
            end
         end
`ifdef SEQ_DIVIDER_SIGNED_EN
         S_FIX: begin
            state_d = S_DONE;
            done_d  = 1'b1;
            quo_d   = neg_quo_q ? WIDTH'(WIDTH'(0) - q_q) : q_q;
            rem_d   = neg_rem_q ? WIDTH'(WIDTH'(0) - r_q) : r_q;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
`endif
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (unsigned by default, signed with SEQ_DIVIDER_SIGNED_EN).
module tb_seq_divider;
   localparam int unsigned W = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif
   // Edges after the sampling edge until done is observed
   localparam int LAT_DBZ = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   seq_divider_if #(.WIDTH(W)) bus ();
   seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one start and wait (bounded) for done
   task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         output int lat, output int bcnt, output bit both);
      bus.dividend = dvd;
      bus.divisor  = dvs;
      bus.start    = 1'b1;
      step();
      bus.start = 1'b0;
      lat = 0; bcnt = 0; both = 1'b0;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (bus.busy === 1'b1) bcnt++;
         step();
         lat++;
      end
      if (bus.busy === 1'b1 && bus.done === 1'b1) both = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      step(); step();
      rst = 1'b0;
      step();
      tests++;
      if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
         fails++; $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.div_by_zero});
      end
      tests++;
      if ({bus.quotient, bus.remainder} !== 16'h0000) begin
         fails++; $display("FAIL reset_results got %h want 0000", {bus.quotient, bus.remainder});
      end
   endtask

   task automatic test_basic();
      int lat, bcnt; bit both;
      run_op(8'd100, 8'd7, lat, bcnt, both);
      tests++;
      if (lat !== LAT) begin fails++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
      tests++;
      if (bcnt !== int'(W)) begin fails++; $display("FAIL basic_busy_cycles got %0d want %0d", bcnt, W); end
      tests++;
      if (both !== 1'b0) begin fails++; $display("FAIL basic_busy_done_overlap got %b want 0", both); end
      tests++;
      if (bus.quotient !== 8'd14 || bus.remainder !== 8'd2 || bus.div_by_zero !== 1'b0) begin
         fails++; $display("FAIL basic_result got q=%0d r=%0d z=%b want q=14 r=2 z=0",
                           bus.quotient, bus.remainder, bus.div_by_zero);
      end
      step();
      tests++;
      if (bus.done !== 1'b0 || bus.quotient !== 8'd14 || bus.remainder !== 8'd2) begin
         fails++; $display("FAIL basic_pulse_hold got done=%b q=%0d r=%0d want done=0 q=14 r=2",
                           bus.done, bus.quotient, bus.remainder);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bcnt; bit both;
      run_op(8'd5, 8'd9, lat, bcnt, both);
      tests++;
      if (bus.quotient !== 8'd0 || bus.remainder !== 8'd5) begin
         fails++; $display("FAIL b2b_first got q=%0d r=%0d want q=0 r=5", bus.quotient, bus.remainder);
      end
      // Still in the DONE cycle: this start must be accepted
      run_op(8'd255, 8'd1, lat, bcnt, both);
      tests++;
      if (lat !== LAT) begin fails++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
      tests++;
      if (bus.quotient !== 8'd255 || bus.remainder !== 8'd0) begin
         fails++; $display("FAIL b2b_second got q=%0d r=%0d want q=255 r=0", bus.quotient, bus.remainder);
      end
      step();
   endtask

   task automatic test_div_zero();
      int lat, bcnt; bit both;
      run_op(8'd200, 8'd0, lat, bcnt, both);
      tests++;
      if (lat !== LAT_DBZ) begin fails++; $display("FAIL dbz_latency got %0d want %0d", lat, LAT_DBZ); end
      tests++;
      if (bus.quotient !== 8'hFF || bus.remainder !== 8'd200 || bus.div_by_zero !== 1'b1) begin
         fails++; $display("FAIL dbz_result got q=%h r=%0d z=%b want q=ff r=200 z=1",
                           bus.quotient, bus.remainder, bus.div_by_zero);
      end
      step();
      tests++;
      if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b1) begin
         fails++; $display("FAIL dbz_hold got done=%b z=%b want done=0 z=1", bus.done, bus.div_by_zero);
      end
      run_op(8'd9, 8'd3, lat, bcnt, both);
      tests++;
      if (bus.quotient !== 8'd3 || bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0) begin
         fails++; $display("FAIL dbz_clear got q=%0d r=%0d z=%b want q=3 r=0 z=0",
                           bus.quotient, bus.remainder, bus.div_by_zero);
      end
      step();
   endtask

   task automatic test_start_ignored();
      int lat;
      bus.dividend = 8'd255; bus.divisor = 8'd255; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.dividend = 8'd17; bus.divisor = 8'd4;
      step(); step();
      bus.dividend = 8'd10; bus.divisor = 8'd2; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.dividend = 8'($urandom_range(0, 255)); bus.divisor = 8'($urandom_range(1, 255));
      lat = 3;
      while (bus.done !== 1'b1 && lat < 40) begin step(); lat++; end
      tests++;
      if (lat !== LAT) begin fails++; $display("FAIL ignore_latency got %0d want %0d", lat, LAT); end
      tests++;
      if (bus.quotient !== 8'd1 || bus.remainder !== 8'd0) begin
         fails++; $display("FAIL ignore_result got q=%0d r=%0d want q=1 r=0", bus.quotient, bus.remainder);
      end
      step();
   endtask

   task automatic test_reset_abort();
      int lat, bcnt; bit both, seen;
      bus.dividend = 8'd100; bus.divisor = 8'd7; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      tests++;
      if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 19'd0) begin
         fails++; $display("FAIL abort_outputs got busy=%b done=%b z=%b q=%0d r=%0d want all 0",
                           bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
      end
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_done got activity=%b want 0", seen); end
      run_op(8'd100, 8'd7, lat, bcnt, both);
      tests++;
      if (lat !== LAT || bus.quotient !== 8'd14 || bus.remainder !== 8'd2) begin
         fails++; $display("FAIL abort_rerun got lat=%0d q=%0d r=%0d want lat=%0d q=14 r=2",
                           lat, bus.quotient, bus.remainder, LAT);
      end
      step();
   endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
   task automatic test_signed();
      int lat, bcnt; bit both;
      run_op(8'h9C, 8'd7, lat, bcnt, both);
      tests++;
      if (lat !== W + 1) begin fails++; $display("FAIL signed_latency got %0d want %0d", lat, W + 1); end
      tests++;
      if (bus.quotient !== 8'hF2 || bus.remainder !== 8'hFE) begin
         fails++; $display("FAIL signed_neg100_7 got q=%h r=%h want q=f2 r=fe", bus.quotient, bus.remainder);
      end
      step();
      run_op(8'h80, 8'hFF, lat, bcnt, both);
      tests++;
      if (bus.quotient !== 8'h80 || bus.remainder !== 8'h00) begin
         fails++; $display("FAIL signed_wrap got q=%h r=%h want q=80 r=00", bus.quotient, bus.remainder);
      end
      step();
   endtask
`else
   task automatic test_edges();
      int lat, bcnt; bit both;
      logic [W-1:0] dvd [4] = '{8'd0, 8'd254, 8'd128, 8'd255};
      logic [W-1:0] dvs [4] = '{8'd5, 8'd255, 8'd2,   8'd2};
      logic [W-1:0] eq  [4] = '{8'd0, 8'd0,   8'd64,  8'd127};
      logic [W-1:0] er  [4] = '{8'd0, 8'd254, 8'd0,   8'd1};
      for (int i = 0; i < 4; i++) begin
         run_op(dvd[i], dvs[i], lat, bcnt, both);
         tests++;
         if (bus.quotient !== eq[i] || bus.remainder !== er[i]) begin
            fails++; $display("FAIL edge_%0d got q=%0d r=%0d want q=%0d r=%0d",
                              i, bus.quotient, bus.remainder, eq[i], er[i]);
         end
         step();
      end
   endtask
`endif

   initial begin
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_start_ignored();
      test_reset_abort();
`ifdef SEQ_DIVIDER_SIGNED_EN
      test_signed();
`else
      test_edges();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
